// File: rtl/l2_mem_pkg.sv
// Shared constants and state type for the L2 data-memory master port.
// Optional per-word write mask is enabled by defining L2_MEM_PORT_WMASK_EN.
package l2_mem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_NONE  = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } l2mp_state_t;

endpackage

// File: rtl/l2_line_buffer.sv
// Refill line buffer: LINE_WORDS x 32-bit register, one indexed word write per
// cycle, full-line read-out.
module l2_line_buffer #(
    parameter int LINE_WORDS = 4,
    localparam int CW = $clog2(LINE_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [CW-1:0]              widx,
    input  logic [31:0]                wdata,
    output logic [LINE_WORDS*32-1:0]   line
);

    logic [LINE_WORDS-1:0][31:0] words;

    always_ff @(posedge clk) begin
        if (reset) begin
            words <= '0;
        end else if (we) begin
            words[widx] <= wdata;
        end
    end

    assign line = words;

endmodule

// File: rtl/l2_mem_port.sv
// Line-granular master port: sequences one L2 refill/writeback into LINE_WORDS
// single-word LOAD/STORE cycles. L2_MEM_PORT_WMASK_EN adds the req_wmask port.
module l2_mem_port
    import l2_mem_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [31:0]                req_addr,
    input  logic [LINE_WORDS*32-1:0]   req_wdata,
`ifdef L2_MEM_PORT_WMASK_EN
    input  logic [LINE_WORDS-1:0]      req_wmask,
`endif
    output logic                       resp_valid,
    output logic [LINE_WORDS*32-1:0]   resp_data,
    output logic [6:0]                 mem_opcode,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata
);

    localparam int CW  = $clog2(LINE_WORDS);
    localparam int OFF = $clog2(LINE_WORDS*4);

    l2mp_state_t                 state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [31:0]                 base_q;
    logic [LINE_WORDS-1:0][31:0] wdata_q;
`ifdef L2_MEM_PORT_WMASK_EN
    logic [LINE_WORDS-1:0]       mask_q;
`endif

    logic        accept;
    logic        last_word;
    logic [31:0] word_addr;
    logic        unused_offset_bits;

    assign req_ready          = (state_q == IDLE) && !reset;
    assign accept             = req_valid && req_ready;
    assign last_word          = (cnt_q == CW'(LINE_WORDS-1));
    // Base is line aligned, so adding 4*cnt never carries out of the line.
    assign word_addr          = base_q + (32'(cnt_q) << 2);
    assign unused_offset_bits = ^req_addr[OFF-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
`ifdef L2_MEM_PORT_WMASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                base_q  <= {req_addr[31:OFF], {OFF{1'b0}}};
                wdata_q <= req_wdata;
`ifdef L2_MEM_PORT_WMASK_EN
                mask_q  <= req_wmask;
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = req_write ? WRITE : READ;
                end
            end
            READ, WRITE: begin
                if (last_word) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes come only from registered state so they settle before the
    // falling-edge store commit.
    always_comb begin
        mem_opcode = OPC_NONE;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            READ: begin
                mem_opcode = OPC_LOAD;
                mem_addr   = word_addr;
            end
            WRITE: begin
`ifdef L2_MEM_PORT_WMASK_EN
                mem_opcode = mask_q[cnt_q] ? OPC_STORE : OPC_NONE;
`else
                mem_opcode = OPC_STORE;
`endif
                mem_addr   = word_addr;
                mem_wdata  = wdata_q[cnt_q];
            end
            default: ;
        endcase
    end

    assign resp_valid = (state_q == RESP);

    l2_line_buffer #(.LINE_WORDS(LINE_WORDS)) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (state_q == READ),
        .widx  (cnt_q),
        .wdata (mem_rdata),
        .line  (resp_data)
    );

endmodule

// File: tb/tb_l2_mem_port.sv
// Bench for l2_mem_port: word-addressed memory model, directed plus random
// line requests checked against expected lines, op traces and fixed latency.
module tb_l2_mem_port;
    import l2_mem_pkg::*;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [31:0]   req_addr;
    logic [127:0]  req_wdata;
    logic          resp_valid;
    logic [127:0]  resp_data;
    logic [6:0]    mem_opcode;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;

    int npass = 0;
    int ntotal = 0;

    // Low 4 KiB is writable; above it every word reads as its address + 1.
    logic [31:0] mem [0:1023];
    logic [6:0]  tr_op[$];
    logic [31:0] tr_addr[$];
    logic [31:0] tr_wd[$];
    logic [127:0] last_line;

    always #5 clk = ~clk;

    l2_mem_port #(.LINE_WORDS(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mem_opcode (mem_opcode),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = (mem_addr < 32'h1000) ? mem[mem_addr[11:2]] : mem_addr + 32'd1;

    // Memory: records every issued op and commits stores on the falling edge.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i*4 + 1);
        forever begin
            @(negedge clk);
            if (mem_opcode != OPC_NONE) begin
                tr_op.push_back(mem_opcode);
                tr_addr.push_back(mem_addr);
                tr_wd.push_back(mem_wdata);
                if (mem_opcode == OPC_STORE && mem_addr < 32'h1000)
                    mem[mem_addr[11:2]] = mem_wdata;
            end
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return (a < 32'h1000) ? mem[a[11:2]] : a + 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [127:0] wd);
        logic [31:0]  base;
        logic [127:0] exp_line;
        base     = {addr[31:4], 4'h0};
        exp_line = last_line;
        if (!wr)
            for (int i = 0; i < LW; i++) exp_line[32*i +: 32] = model_rd(base + 32'(i*4));
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        tr_op.delete(); tr_addr.delete(); tr_wd.delete();
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= LW + 2; k++) begin
            @(negedge clk);
            if (k <= LW + 1) begin
                chk($sformatf("resp_valid_k%0d", k), resp_valid, (k == LW + 1));
                chk($sformatf("ready_busy_k%0d", k), req_ready, 0);
            end
            if (k == LW + 1) chk("resp_data", resp_data, exp_line);
            if (k == LW + 2) begin
                chk("ready_again", req_ready, 1);
                chk("resp_pulse_end", resp_valid, 0);
            end
        end
        chk("trace_len", tr_op.size(), LW);
        for (int i = 0; i < LW && i < tr_op.size(); i++) begin
            chk($sformatf("op%0d", i), tr_op[i], wr ? OPC_STORE : OPC_LOAD);
            chk($sformatf("addr%0d", i), tr_addr[i], base + 32'(i*4));
            if (wr) chk($sformatf("wdata%0d", i), tr_wd[i], wd[32*i +: 32]);
        end
        if (wr && base < 32'h1000)
            for (int i = 0; i < LW; i++)
                chk($sformatf("mem_after_wb%0d", i), mem[base[11:2] + 10'(i)], wd[32*i +: 32]);
        last_line = exp_line;
    endtask

    initial begin
        logic [127:0] l1, l2, wdr;
        logic [31:0]  old3;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        last_line = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_opcode", mem_opcode, OPC_NONE);
        chk("rst_addr", mem_addr, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Refill of the line holding 0x14.
        run_req(1'b0, 32'h0000_0014, '0);
        chk("refill_const", resp_data, 128'h0000001D_00000019_00000015_00000011);
        // Writeback must not disturb the refill buffer.
        run_req(1'b1, 32'h0000_0040, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("wb_keeps_buf", resp_data, 128'h0000001D_00000019_00000015_00000011);
        // Top-of-address-space line: no wrap.
        run_req(1'b0, 32'hFFFF_FFF4, '0);
        chk("top_line", resp_data, 128'hFFFFFFFD_FFFFFFF9_FFFFFFF5_FFFFFFF1);

        // Back-to-back with req_valid held.
        for (int i = 0; i < LW; i++) l2[32*i +: 32] = model_rd(32'h30 + 32'(i*4));
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
        @(posedge clk); #1 req_addr = 32'h30;
        for (int k = 1; k <= LW + 2; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_k%0d", k), req_ready, (k == LW + 2));
        end
        @(posedge clk); #1 req_valid = 1'b0;
        for (int k = 1; k <= LW + 1; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_resp_k%0d", k), resp_valid, (k == LW + 1));
        end
        chk("b2b_data", resp_data, l2);
        last_line = l2;
        @(negedge clk);

        // Reset during WRITE with cnt==2.
        wdr  = {$urandom, $urandom, $urandom, $urandom};
        old3 = mem[(32'h20C >> 2)];
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = wdr;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_store", mem_opcode, OPC_STORE);
        @(negedge clk);
        chk("mid_opcode", mem_opcode, OPC_NONE);
        chk("mid_addr", mem_addr, 0);
        chk("mid_wdata", mem_wdata, 0);
        chk("mid_resp_valid", resp_valid, 0);
        chk("mid_ready", req_ready, 0);
        chk("mid_resp_data", resp_data, 0);
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < LW + 2; k++) begin
            @(negedge clk);
            chk("mid_no_resp", resp_valid, 0);
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("mid_word%0d", i), mem[(32'h200 >> 2) + i], wdr[32*i +: 32]);
        chk("mid_word3", mem[(32'h20C >> 2)], old3);
        last_line = '0;

        // Random mix of refills and writebacks.
        for (int n = 0; n < 16; n++) begin
            logic        wr;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 32'hFFF);
            if (!wr && (n % 5 == 4)) a = $urandom | 32'h1000_0000;
            run_req(wr, a, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
